// File: rtl/branch_predictor.sv
// Fetch-side direction/target predictor: direct-mapped, tagged table of 2-bit counters plus
// targets, looked up once per fetched PC and trained by resolved branches from execute.
module branch_predictor #(
  parameter int unsigned WordSize  = 32,
  parameter int unsigned IndexBits = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                fetch_valid,
  input  logic [WordSize-1:0] fetch_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [WordSize-1:0] pred_pc,
  output logic [WordSize-1:0] pred_addr,
  input  logic                upd_valid,
  input  logic [WordSize-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [WordSize-1:0] upd_target
);

  localparam int          Entries = 1 << IndexBits;
  localparam int unsigned TagBits = WordSize - IndexBits - 2;

  logic [Entries-1:0] valid_q;
  logic [TagBits-1:0] tag_q    [Entries];
  logic [1:0]         ctr_q    [Entries];
  logic [WordSize-1:0] target_q [Entries];

  logic                pred_valid_q, pred_taken_q;
  logic [WordSize-1:0] pred_pc_q, pred_addr_q;

  logic [IndexBits-1:0] lk_idx, upd_idx;
  logic [TagBits-1:0]   lk_tag, upd_tag;
  logic                 lk_hit, lk_taken, upd_hit;
  logic [WordSize-1:0]  lk_addr;
  logic [1:0]           upd_ctr_d;
  logic                 fetch_accept;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  always_comb begin
    lk_idx   = fetch_pc[IndexBits+1:2];
    lk_tag   = fetch_pc[WordSize-1:IndexBits+2];
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken = lk_hit && ctr_q[lk_idx][1];
    lk_addr  = lk_taken ? target_q[lk_idx] : fetch_pc + WordSize'(4);

    upd_idx  = upd_pc[IndexBits+1:2];
    upd_tag  = upd_pc[WordSize-1:IndexBits+2];
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_ctr_d = ctr_q[upd_idx];
    if (upd_taken) begin
      if (upd_ctr_d != 2'b11) upd_ctr_d = upd_ctr_d + 2'b01;
    end else begin
      if (upd_ctr_d != 2'b00) upd_ctr_d = upd_ctr_d - 2'b01;
    end

    fetch_accept = fetch_valid && !flush;
  end

  // Lookup reads the table before this edge's update lands (read-old).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_pc_q    <= '0;
      pred_addr_q  <= '0;
    end else begin
      pred_valid_q <= fetch_accept;
      if (fetch_accept) begin
        pred_taken_q <= lk_taken;
        pred_pc_q    <= fetch_pc;
        pred_addr_q  <= lk_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= 2'b01;
        target_q[i] <= '0;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_ctr_d;
        if (upd_taken) target_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        // Taken miss allocates weakly-taken, evicting any alias at this index.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        ctr_q[upd_idx]    <= 2'b10;
        target_q[upd_idx] <= upd_target;
      end
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_pc    = pred_pc_q;
  assign pred_addr  = pred_addr_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor producing the `pred_taken`, `pred_pc` and `pred_addr` triple consumed by Branch_Manager.
- Direct-mapped, tagged table of 2-bit saturating counters plus branch targets (a combined BHT/BTB).
- Looked up once per fetched PC; trained by resolved-branch updates from execute.
- Sits between the fetch PC register and the branch manager; flushes from the manager kill any in-flight prediction.

Parameters:
- WordSize, 32, width of PCs and targets.
- IndexBits, 4, log2 of table entries (16 entries at default).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rstn  input  1  reset; synchronous, active-low.
- flush  input  1  mispredict flush from branch manager; kills the prediction registered this cycle.
- fetch_valid  input  1  a PC is presented for lookup.
- fetch_pc  input  WordSize  PC to predict.
- pred_valid  output  1  prediction outputs are meaningful.
- pred_taken  output  1  predicted direction.
- pred_pc  output  WordSize  PC the prediction belongs to.
- pred_addr  output  WordSize  predicted next PC: target if taken, else pred_pc+4.
- upd_valid  input  1  resolved branch update this cycle.
- upd_pc  input  WordSize  PC of resolved branch.
- upd_taken  input  1  actual direction.
- upd_target  input  WordSize  actual taken target.

Behaviour:
- Address split:
  - index = pc[IndexBits+1:2].
  - tag = pc[WordSize-1:IndexBits+2].
  - pc[1:0] are ignored.
- Per-entry state: valid (1), tag, ctr (2), target (WordSize).
- Reset (rstn low at posedge):
  - All entries: valid=0, ctr=2'b01, tag=0, target=0.
  - pred_valid=0, pred_taken=0, pred_pc=0, pred_addr=0.
  - Reset dominates flush, lookup and update.
- Lookup: 1-cycle latency. With fetch_valid=1 at edge N, the outputs at N+1 reflect table state before any update written at edge N (read-old).
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_addr = pred_taken ? target : fetch_pc+4 (mod 2^WordSize, wraps).
  - pred_pc = fetch_pc.
  - pred_valid = 1.
- fetch_valid=0 at an edge: pred_valid goes 0 at that edge; pred_taken, pred_pc and pred_addr hold their values.
- flush=1 at an edge:
  - pred_valid goes 0 regardless of fetch_valid; the other pred outputs hold.
  - Updates in the same cycle still apply.
- Update (upd_valid=1, applied at the edge), hit case (valid && tag match):
  - Taken: ctr saturating increment, max 2'b11; target <= upd_target.
  - Not taken: ctr saturating decrement, min 2'b00; target unchanged.
- Update, miss case:
  - upd_taken=1: allocate or overwrite the entry at that index. valid=1, tag=upd tag, target=upd_target, ctr=2'b10 (weakly taken).
  - upd_taken=0: no table change; a not-taken miss never allocates.
- Same-index lookup and update in one cycle: lookup returns the pre-update entry; the update is visible to lookups from the next edge onward.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Aliasing: a differing tag at the same index is a miss. A taken update evicts the old entry.
- Storage: regular flops, all synchronous; no memory macro.

Test Plan:
- Reset then lookup:
  - Stimulus: rstn=0 for 2 cycles, release; fetch_pc=0x100.
  - Required: next cycle pred_valid=1, pred_taken=0, pred_pc=0x100, pred_addr=0x104.
- Allocate and predict:
  - Stimulus: update pc=0x108, taken=1, target=0x200; then lookup 0x108.
  - Required: pred_taken=1, pred_addr=0x200, entry ctr=2'b10.
- Saturation/hysteresis:
  - Stimulus: from ctr=10, apply 3 taken updates.
  - Required: ctr=11, stays 11.
  - Stimulus: then 1 not-taken update.
  - Required: ctr=10, lookup still predicts taken.
  - Stimulus: a second not-taken update.
  - Required: ctr=01, lookup predicts not taken, pred_addr=0x10C.
- Aliasing:
  - Stimulus: entry for 0x108 valid; lookup 0x148 (same index 2, different tag).
  - Required: miss, pred_taken=0, pred_addr=0x14C.
  - Stimulus: not-taken update at 0x148.
  - Required: 0x108 entry untouched.
  - Stimulus: taken update at 0x148, target=0x300.
  - Required: 0x108 now misses.
- Same-cycle conflict:
  - Stimulus: lookup 0x108 and not-taken update 0x108 in the same cycle, with ctr=10.
  - Required: this prediction is taken; the following lookup is not taken.
- Flush and wrap:
  - Stimulus: fetch_valid=1 and flush=1 together.
  - Required: pred_valid=0 next cycle; a simultaneous taken update still allocates.
  - Stimulus: lookup 0xFFFFFFFC on a miss.
  - Required: pred_addr=0x00000000.
